// File: rtl/data_memory_ws.sv
// rtl/data_memory_ws.sv - byte-addressed little-endian data memory with wait states
module data_memory_ws #(
    parameter int DEPTH_BYTES = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);
    localparam int         AW  = $clog2(DEPTH_BYTES);
    localparam logic [3:0] LAT = 4'(LATENCY);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    logic [7:0] mem [DEPTH_BYTES];

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [1:0]    size_q, size_d;
    logic          uns_q, uns_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic          idle;
    logic          accept;
    logic          access;
    logic          mem_we;
    logic          eff_we;
    logic [AW-1:0] eff_addr;
    logic [1:0]    eff_size;
    logic          eff_uns;
    logic [31:0]   eff_wdata;
    logic          eff_err;
    logic [AW-1:0] a1, a2, a3;
    logic [7:0]    b0, b1, b2, b3;
    logic [31:0]   load_val;
    logic          unused_addr;

    assign unused_addr = ^addr_i[31:AW];

    assign idle   = (state_q == S_IDLE);
    assign accept = idle && req_i;

    // With zero wait states the access happens on the accept edge, so the
    // live inputs are used there; otherwise the captured copy is used.
    assign eff_we    = idle ? we_i             : we_q;
    assign eff_addr  = idle ? addr_i[AW-1:0]   : addr_q;
    assign eff_size  = idle ? size_i           : size_q;
    assign eff_uns   = idle ? unsigned_i       : uns_q;
    assign eff_wdata = idle ? wdata_i          : wdata_q;

    assign access = (accept && (LAT == 4'd0)) ||
                    ((state_q == S_WAIT) && (cnt_q == 4'd1));

    always_comb begin
        eff_err = 1'b0;
        case (eff_size)
            SZ_BYTE: eff_err = 1'b0;
            SZ_HALF: eff_err = eff_addr[0];
            SZ_WORD: eff_err = (eff_addr[1:0] != 2'b00);
            default: eff_err = 1'b1;
        endcase
    end

    assign a1 = eff_addr + AW'(1);
    assign a2 = eff_addr + AW'(2);
    assign a3 = eff_addr + AW'(3);
    assign b0 = mem[eff_addr];
    assign b1 = mem[a1];
    assign b2 = mem[a2];
    assign b3 = mem[a3];

    always_comb begin
        load_val = 32'd0;
        if (!eff_err) begin
            case (eff_size)
                SZ_BYTE: load_val = {{24{~eff_uns & b0[7]}}, b0};
                SZ_HALF: load_val = {{16{~eff_uns & b1[7]}}, b1, b0};
                SZ_WORD: load_val = {b3, b2, b1, b0};
                default: load_val = 32'd0;
            endcase
        end
    end

    // Reset gating keeps a store from landing while the block is held in reset.
    assign mem_we = access && eff_we && !eff_err && rst_n_i;

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[eff_addr] <= eff_wdata[7:0];
            if (eff_size != SZ_BYTE) begin
                mem[a1] <= eff_wdata[15:8];
            end
            if (eff_size == SZ_WORD) begin
                mem[a2] <= eff_wdata[23:16];
                mem[a3] <= eff_wdata[31:24];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        size_d  = size_q;
        uns_d   = uns_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    we_d    = we_i;
                    addr_d  = addr_i[AW-1:0];
                    size_d  = size_i;
                    uns_d   = unsigned_i;
                    wdata_d = wdata_i;
                    if (LAT == 4'd0) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = LAT;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (access) begin
            err_d = eff_err;
            if (!eff_we) begin
                rdata_d = load_val;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign stall_o = accept || (state_q == S_WAIT);
    assign done_o  = (state_q == S_DONE);
    assign err_o   = done_o && err_q;
    assign rdata_o = rdata_q;

endmodule

// File: tb/tb_data_memory_ws.sv
// tb/tb_data_memory_ws.sv - scoreboard bench for data_memory_ws over three configurations
module tb_data_memory_ws;
    logic        clk = 1'b0;
    logic        rst_n [3];
    logic        req   [3];
    logic        we    [3];
    logic [31:0] addr  [3];
    logic [1:0]  size  [3];
    logic        uns   [3];
    logic [31:0] wdata [3];
    logic        stall [3];
    logic        done  [3];
    logic [31:0] rdata [3];
    logic        err   [3];

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb_q [$];
    int          lat [3] = '{2, 0, 4};
    logic [31:0] last_rd [3];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    data_memory_ws #(.DEPTH_BYTES(1024), .LATENCY(2)) u_l2 (
        .clk_i(clk), .rst_n_i(rst_n[0]), .req_i(req[0]), .we_i(we[0]),
        .addr_i(addr[0]), .size_i(size[0]), .unsigned_i(uns[0]), .wdata_i(wdata[0]),
        .stall_o(stall[0]), .done_o(done[0]), .rdata_o(rdata[0]), .err_o(err[0]));

    data_memory_ws #(.DEPTH_BYTES(32), .LATENCY(0)) u_l0 (
        .clk_i(clk), .rst_n_i(rst_n[1]), .req_i(req[1]), .we_i(we[1]),
        .addr_i(addr[1]), .size_i(size[1]), .unsigned_i(uns[1]), .wdata_i(wdata[1]),
        .stall_o(stall[1]), .done_o(done[1]), .rdata_o(rdata[1]), .err_o(err[1]));

    data_memory_ws #(.DEPTH_BYTES(1024), .LATENCY(4)) u_l4 (
        .clk_i(clk), .rst_n_i(rst_n[2]), .req_i(req[2]), .we_i(we[2]),
        .addr_i(addr[2]), .size_i(size[2]), .unsigned_i(uns[2]), .wdata_i(wdata[2]),
        .stall_o(stall[2]), .done_o(done[2]), .rdata_o(rdata[2]), .err_o(err[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic access(input int d, input logic w, input logic [31:0] a,
                          input logic [1:0] sz, input logic u, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err, input string tag);
        exp_t e;
        exp_t got_e;
        int   n_stall;
        bit   got;
        e.rdata = w ? last_rd[d] : exp_rd;
        e.err   = exp_err;
        sb_q.push_back(e);
        if (!w) last_rd[d] = exp_rd;
        @(negedge clk);
        we[d] = w; addr[d] = a; size[d] = sz; uns[d] = u; wdata[d] = wd; req[d] = 1'b1;
        n_stall = 0;
        got = 1'b0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (done[d]) begin
                got = 1'b1;
                break;
            end
            if (stall[d]) n_stall++;
            if (c == 1) begin
                // request inputs changing mid-access must be ignored
                we[d] = ~w; addr[d] = 32'hFFFF_FFFD; size[d] = 2'b11; wdata[d] = 32'h0;
            end
            @(negedge clk);
        end
        chk({tag, " done_seen"}, {31'd0, got}, 32'd1);
        if (got) begin
            got_e = sb_q.pop_front();
            chk({tag, " rdata"}, rdata[d], got_e.rdata);
            chk({tag, " err"}, {31'd0, err[d]}, {31'd0, got_e.err});
            chk({tag, " stall_in_done"}, {31'd0, stall[d]}, 32'd0);
            chk({tag, " stall_len"}, n_stall, lat[d] + 1);
        end
        // req_i is still high during DONE and must not start a new access
        req[d] = 1'b0;
        @(negedge clk);
        #1;
        chk({tag, " done_pulse"}, {31'd0, done[d]}, 32'd0);
        chk({tag, " no_reaccept"}, {31'd0, stall[d]}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst_n[i] = 1'b0; req[i] = 1'b0; we[i] = 1'b0; addr[i] = 32'd0;
            size[i] = 2'b00; uns[i] = 1'b0; wdata[i] = 32'd0; last_rd[i] = 32'd0;
        end
        repeat (2) @(negedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset%0d stall", i), {31'd0, stall[i]}, 32'd0);
            chk($sformatf("reset%0d done", i), {31'd0, done[i]}, 32'd0);
            chk($sformatf("reset%0d err", i), {31'd0, err[i]}, 32'd0);
            chk($sformatf("reset%0d rdata", i), rdata[i], 32'd0);
        end
        @(negedge clk);
        for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;

        access(0, 1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0, "st_w10");
        access(0, 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, "ld_w10");
        access(0, 1'b0, 32'h10, 2'b00, 1'b1, 32'h0, 32'h000000EF, 1'b0, "ld_bu10");
        access(0, 1'b0, 32'h13, 2'b00, 1'b0, 32'h0, 32'hFFFFFFDE, 1'b0, "ld_b13");
        access(0, 1'b0, 32'h13, 2'b00, 1'b1, 32'h0, 32'h000000DE, 1'b0, "ld_bu13");
        access(0, 1'b0, 32'h10, 2'b01, 1'b0, 32'h0, 32'hFFFFBEEF, 1'b0, "ld_h10");
        access(0, 1'b0, 32'h12, 2'b01, 1'b1, 32'h0, 32'h0000DEAD, 1'b0, "ld_hu12");
        access(0, 1'b1, 32'h11, 2'b00, 1'b0, 32'h12345655, 32'h0, 1'b0, "st_b11");
        access(0, 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 32'hDEAD55EF, 1'b0, "ld_w10b");
        access(0, 1'b1, 32'h20, 2'b10, 1'b0, 32'hA5A5A5A5, 32'h0, 1'b0, "st_w20");
        access(0, 1'b1, 32'h22, 2'b10, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b1, "st_w22_mis");
        access(0, 1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 32'hA5A5A5A5, 1'b0, "ld_w20");
        access(0, 1'b0, 32'h05, 2'b01, 1'b0, 32'h0, 32'h00000000, 1'b1, "ld_h05_mis");
        access(0, 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 32'hDEAD55EF, 1'b0, "ld_w10c");
        access(0, 1'b0, 32'h10, 2'b11, 1'b0, 32'h0, 32'h00000000, 1'b1, "ld_rsv");
        access(0, 1'b1, 32'h10, 2'b11, 1'b0, 32'h01020304, 32'h0, 1'b1, "st_rsv");
        access(0, 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 32'hDEAD55EF, 1'b0, "ld_w10d");

        access(1, 1'b1, 32'h24, 2'b10, 1'b0, 32'hCAFEF00D, 32'h0, 1'b0, "l0_st_w24");
        access(1, 1'b0, 32'h04, 2'b10, 1'b0, 32'h0, 32'hCAFEF00D, 1'b0, "l0_ld_w04");
        access(1, 1'b0, 32'h1006, 2'b01, 1'b1, 32'h0, 32'h0000CAFE, 1'b0, "l0_ld_hu06");

        access(2, 1'b1, 32'h08, 2'b10, 1'b0, 32'h22222222, 32'h0, 1'b0, "l4_st_w08");
        access(2, 1'b0, 32'h08, 2'b10, 1'b0, 32'h0, 32'h22222222, 1'b0, "l4_ld_w08");
        @(negedge clk);
        we[2] = 1'b1; addr[2] = 32'h08; size[2] = 2'b10; wdata[2] = 32'h11111111; req[2] = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_mid stall_before", {31'd0, stall[2]}, 32'd1);
        rst_n[2] = 1'b0;
        req[2] = 1'b0;
        #1;
        chk("rst_mid stall", {31'd0, stall[2]}, 32'd0);
        chk("rst_mid done", {31'd0, done[2]}, 32'd0);
        chk("rst_mid err", {31'd0, err[2]}, 32'd0);
        chk("rst_mid rdata", rdata[2], 32'd0);
        last_rd[2] = 32'd0;
        repeat (4) @(negedge clk);
        rst_n[2] = 1'b1;
        access(2, 1'b0, 32'h08, 2'b10, 1'b0, 32'h0, 32'h22222222, 1'b0, "l4_ld_after_rst");

        chk("scoreboard_empty", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
